sa_feeder: RTL and testbench



---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_skew_lane.sv | 24 ++
 rtl/sa_feeder.sv | 101 ++++++++++
 tb/tb_sa_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array edge feeder.
package sa_pkg;

   localparam int unsigned SA_N = 4;
   localparam int unsigned SA_W = 8;
   localparam int unsigned FEED_CYCLES = 3 * SA_N - 2;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DONE
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(3 * n - 1);
   endfunction

   function automatic int unsigned feed_cycles(input int unsigned n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skewed edge lane: presents element (count - LANE) of its row/column, or zero.
module sa_skew_lane
   import sa_pkg::*;
#(
   parameter int unsigned N    = SA_N,
   parameter int unsigned W    = SA_W,
   parameter int unsigned LANE = 0,
   parameter int unsigned CW   = cnt_width(N)
) (
   input  logic [CW-1:0]  i_count,
   input  logic [N*W-1:0] i_elems,
   output logic [W-1:0]   o_elem
);

   always_comb begin
      o_elem = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if ({{(32 - CW){1'b0}}, i_count} == LANE + k) begin
            o_elem = i_elems[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/sa_feeder.sv
// Latches two NxN operands on start and streams them skewed into the PE grid edges.
module sa_feeder
   import sa_pkg::*;
#(
   parameter int unsigned N = SA_N,
   parameter int unsigned W = SA_W
) (
   input  logic             i_clk,
   input  logic             i_arst_n,
   input  logic             i_start,
   input  logic [N*N*W-1:0] i_matA,
   input  logic [N*N*W-1:0] i_matB,
   output logic             o_ready,
   output logic             o_doProcess,
   output logic [N*W-1:0]   o_a,
   output logic [N*W-1:0]   o_b,
   output logic             o_done
);

   localparam int unsigned    CW   = cnt_width(N);
   localparam logic [CW-1:0]  LAST = CW'(feed_cycles(N) - 1);

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic [N*N*W-1:0] r_matA, r_matB;
   logic [N*N*W-1:0] w_matBT;
   logic [N*W-1:0]   w_lane_a, w_lane_b;
   logic             w_accept;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= IDLE;
         r_count <= '0;
         r_matA  <= '0;
         r_matB  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_accept) begin
            r_matA <= i_matA;
            r_matB <= i_matB;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_accept    = 1'b0;
      o_ready     = 1'b0;
      o_doProcess = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_start) begin
               w_accept    = 1'b1;
               w_count_nxt = '0;
               w_state_nxt = FEED;
            end
         end
         FEED: begin
            o_doProcess = 1'b1;
            if (r_count == LAST) begin
               w_count_nxt = '0;
               w_state_nxt = DONE;
            end else begin
               w_count_nxt = r_count + CW'(1);
            end
         end
         DONE: begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Column c of B is scattered across rows; transpose so each B lane sees a contiguous vector.
   for (genvar g = 0; g < N; g++) begin : g_lane
      for (genvar k = 0; k < N; k++) begin : g_tr
         assign w_matBT[(g*N+k)*W +: W] = r_matB[(k*N+g)*W +: W];
      end

      sa_skew_lane #(.N(N), .W(W), .LANE(g), .CW(CW)) u_lane_a (
         .i_count (r_count),
         .i_elems (r_matA[g*N*W +: N*W]),
         .o_elem  (w_lane_a[g*W +: W])
      );

      sa_skew_lane #(.N(N), .W(W), .LANE(g), .CW(CW)) u_lane_b (
         .i_count (r_count),
         .i_elems (w_matBT[g*N*W +: N*W]),
         .o_elem  (w_lane_b[g*W +: W])
      );
   end

   assign o_a = (r_state == FEED) ? w_lane_a : '0;
   assign o_b = (r_state == FEED) ? w_lane_b : '0;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: N=2 and N=4 instances against a phase-indexed model plus a behavioural PE grid.
module tb_sa_feeder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start2 = 1'b0, start4 = 1'b0;
   logic [31:0]   matA2 = '0, matB2 = '0;
   logic [127:0]  matA4 = '0, matB4 = '0;
   logic          rdy2, dp2, dn2, rdy4, dp4, dn4;
   logic [15:0]   a2, b2;
   logic [31:0]   a4, b4;

   sa_feeder #(.N(2), .W(8)) u_dut2 (
      .i_clk(clk), .i_arst_n(rst_n), .i_start(start2), .i_matA(matA2), .i_matB(matB2),
      .o_ready(rdy2), .o_doProcess(dp2), .o_a(a2), .o_b(b2), .o_done(dn2)
   );

   sa_feeder #(.N(4), .W(8)) u_dut4 (
      .i_clk(clk), .i_arst_n(rst_n), .i_start(start4), .i_matA(matA4), .i_matB(matB4),
      .o_ready(rdy4), .o_doProcess(dp4), .o_a(a4), .o_b(b4), .o_done(dn4)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int nof(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   // Model: ph=0 idle, 1..3n-2 feed step t=ph-1, 3n-1 done.
   int ph[2];
   int mA[2][4][4];
   int mB[2][4][4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph[0] = 0;
         ph[1] = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            int n;
            logic st;
            logic [127:0] ma, mb;
            n  = nof(k);
            st = (k == 1) ? start4 : start2;
            ma = (k == 1) ? matA4 : {96'b0, matA2};
            mb = (k == 1) ? matB4 : {96'b0, matB2};
            if (ph[k] == 0) begin
               if (st) begin
                  ph[k] = 1;
                  for (int r = 0; r < n; r++)
                     for (int c = 0; c < n; c++) begin
                        mA[k][r][c] = int'(ma[(r*n+c)*8 +: 8]);
                        mB[k][r][c] = int'(mb[(r*n+c)*8 +: 8]);
                     end
               end
            end else if (ph[k] == 3*n - 1) begin
               ph[k] = 0;
            end else begin
               ph[k] = ph[k] + 1;
            end
         end
      end
   end

   task automatic check_inst(input int k, input logic rdy, input logic dp, input logic dn,
                             input logic [127:0] a, input logic [127:0] b);
      int n, t, ea, eb;
      bit feeding;
      n = nof(k);
      t = ph[k] - 1;
      feeding = (ph[k] >= 1) && (ph[k] <= 3*n - 2);
      chk($sformatf("N%0d ready", n), rdy, ph[k] == 0);
      chk($sformatf("N%0d doProcess", n), dp, feeding);
      chk($sformatf("N%0d done", n), dn, ph[k] == 3*n - 1);
      for (int r = 0; r < n; r++) begin
         ea = 0;
         eb = 0;
         if (feeding && t - r >= 0 && t - r < n) begin
            ea = mA[k][r][t-r];
            eb = mB[k][t-r][r];
         end
         chk($sformatf("N%0d a lane%0d t=%0d", n, r, t), a[r*8 +: 8], ea);
         chk($sformatf("N%0d b lane%0d t=%0d", n, r, t), b[r*8 +: 8], eb);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_inst(0, rdy2, dp2, dn2, {112'b0, a2}, {112'b0, b2});
         check_inst(1, rdy4, dp4, dn4, {96'b0, a4}, {96'b0, b4});
      end
   end

   // Behavioural PE grid fed by the DUT streams: acc += a*b, a passes right, b passes down.
   int acc[2][4][4];
   int pa[2][4][4];
   int pb[2][4][4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  acc[k][r][c] = 0;
                  pa[k][r][c]  = 0;
                  pb[k][r][c]  = 0;
               end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if ((k == 1) ? dp4 : dp2) begin
               for (int r = nof(k) - 1; r >= 0; r--)
                  for (int c = nof(k) - 1; c >= 0; c--) begin
                     int ain, bin;
                     if (c == 0) ain = (k == 1) ? int'(a4[r*8 +: 8]) : int'(a2[r*8 +: 8]);
                     else        ain = pa[k][r][c-1];
                     if (r == 0) bin = (k == 1) ? int'(b4[c*8 +: 8]) : int'(b2[c*8 +: 8]);
                     else        bin = pb[k][r-1][c];
                     acc[k][r][c] = acc[k][r][c] + ain * bin;
                     pa[k][r][c]  = ain;
                     pb[k][r][c]  = bin;
                  end
            end
         end
      end
   end

   logic [127:0] rec_a[64];
   logic [127:0] rec_b[64];

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_measure(input int k, output int cyc, output int dpc);
      logic d;
      @(negedge clk);
      if (k == 1) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      start4 = 1'b0;
      cyc = 0;
      dpc = 0;
      d   = 1'b0;
      while (!d && cyc < 60) begin
         @(negedge clk);
         cyc++;
         rec_a[cyc] = (k == 1) ? {96'b0, a4} : {112'b0, a2};
         rec_b[cyc] = (k == 1) ? {96'b0, b4} : {112'b0, b2};
         if ((k == 1) ? dp4 : dp2) dpc++;
         d = (k == 1) ? dn4 : dn2;
      end
   endtask

   int exp_a0[4] = '{1, 2, 0, 0};
   int exp_a1[4] = '{0, 3, 4, 0};
   int exp_b0[4] = '{5, 7, 0, 0};
   int exp_b1[4] = '{0, 6, 8, 0};
   int exp_y2[2][2] = '{'{19, 22}, '{43, 50}};

   initial begin
      int cyc, dpc;
      logic [127:0] ra;

      // Reset values, then N=2 skew and end-to-end product
      #1;
      chk("reset ready2", rdy2, 1'b1);
      chk("reset doProcess2", dp2, 1'b0);
      chk("reset a4", a4, 0);
      do_reset();
      chk("post-reset ready4", rdy4, 1'b1);
      matA2 = 32'h04030201;
      matB2 = 32'h08070605;
      run_measure(0, cyc, dpc);
      chk("N2 accept-to-done", cyc, 5);
      chk("N2 doProcess cycles", dpc, 4);
      for (int i = 0; i < 4; i++) begin
         ra = rec_a[i+1];
         chk($sformatf("s2 a lane0 t%0d", i), ra[7:0], exp_a0[i]);
         chk($sformatf("s2 a lane1 t%0d", i), ra[15:8], exp_a1[i]);
         ra = rec_b[i+1];
         chk($sformatf("s2 b lane0 t%0d", i), ra[7:0], exp_b0[i]);
         chk($sformatf("s2 b lane1 t%0d", i), ra[15:8], exp_b1[i]);
      end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            chk($sformatf("N2 PE y[%0d][%0d]", r, c), acc[0][r][c], exp_y2[r][c]);

      // Starts during FEED/last FEED/DONE ignored; matA change after accept has no effect
      do_reset();
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      matA2  = 32'hFFFF_FFFF;
      cyc = 0;
      while (!dn2 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         rec_a[cyc] = {112'b0, a2};
         start2 = (cyc == 2 || cyc == 4 || dn2);
      end
      chk("s4 accept-to-done", cyc, 5);
      ra = rec_a[2];
      chk("s4 latched A01", ra[7:0], 2);
      ra = rec_a[3];
      chk("s4 latched A11", ra[15:8], 4);
      @(posedge clk);
      #1;
      start2 = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("s4 no second run ready", rdy2, 1'b1);
         chk("s4 no second run doProcess", dp2, 1'b0);
      end

      // N=4 identity x B -> y = B, done 11 cycles after accept
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            matA4[(r*4+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
            matB4[(r*4+c)*8 +: 8] = 8'(16*r + c + 1);
         end
      run_measure(1, cyc, dpc);
      chk("N4 accept-to-done", cyc, 11);
      chk("N4 doProcess cycles", dpc, 10);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            chk($sformatf("N4 PE y[%0d][%0d]", r, c), acc[1][r][c], 16*r + c + 1);

      // Asynchronous reset mid-FEED
      do_reset();
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      repeat (3) @(negedge clk);
      chk("s1 in FEED before reset", dp4, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s1 async ready", rdy4, 1'b1);
      chk("s1 async doProcess", dp4, 1'b0);
      chk("s1 async done", dn4, 1'b0);
      chk("s1 async a", a4, 0);
      chk("s1 async b", b4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s1 ready after release", rdy4, 1'b1);

      // Back-to-back with start held high
      @(negedge clk);
      start4 = 1'b1;
      cyc = 0;
      while (!dn4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b first done", cyc, 11);
      @(negedge clk);
      chk("b2b idle gap ready", rdy4, 1'b1);
      chk("b2b idle gap doProcess", dp4, 1'b0);
      @(negedge clk);
      chk("b2b second run started", dp4, 1'b1);
      cyc = 2;
      while (!dn4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b done-to-done", cyc, 12);
      start4 = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b settles idle", rdy4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
